// File: rtl/multdiv_if.sv
// Start/operand/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth) and divide (non-restoring on
// magnitudes) sharing one adder built from chained 8-bit carry-lookahead slices.
//
// state  | meaning
// S_IDLE | waiting for a start pulse; outputs hold the last completed result
// S_MUL  | 16 Booth iterations, then writeback of product/overflow
// S_DIV  | one load cycle (magnitudes, sign), then 32 quotient iterations
// S_FIX  | sign-correct quotient, apply divide special cases, pulse ready
module multdiv (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [33:0] acc_hi;
    logic [31:0] acc_lo;
    logic        guard;
    logic        loaded;
    logic        q_sign;
    logic        div_ovf;
    logic [31:0] result;
    logic        exception;
    logic        rdy;

    logic [2:0]  booth;
    logic [33:0] booth_op;
    logic        booth_neg;
    logic [33:0] mul_sum;
    logic [32:0] r_sh;
    logic [33:0] div_sum;
    logic [32:0] p_top;

    assign bus.data_result    = result;
    assign bus.data_exception = exception;
    assign bus.data_resultRDY = rdy;

    function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
        return {c[8], p ^ c[7:0]};
    endfunction

    function automatic logic [32:0] cla32(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [31:0] sum;
        logic [8:0]  slice;
        logic        c;
        c   = cin;
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            slice          = cla8(a[8*k +: 8], b[8*k +: 8], c);
            sum[8*k +: 8]  = slice[7:0];
            c              = slice[8];
        end
        return {c, sum};
    endfunction

    // Two sign-extension bits above the 32-bit adder absorb the +/-2A Booth
    // term and the shifted divide remainder without overflowing.
    function automatic logic [33:0] add34(input logic [33:0] a, input logic [33:0] b, input logic cin);
        logic [32:0] lo;
        logic [1:0]  hi;
        lo = cla32(a[31:0], b[31:0], cin);
        hi = a[33:32] + b[33:32] + {1'b0, lo[32]};
        return {hi, lo[31:0]};
    endfunction

    always_comb begin
        booth     = {acc_lo[1:0], guard};
        booth_op  = '0;
        booth_neg = 1'b0;
        case (booth)
            3'b001, 3'b010: booth_op = {{2{op_a[31]}}, op_a};
            3'b011:         booth_op = {op_a[31], op_a, 1'b0};
            3'b100: begin
                booth_op  = {op_a[31], op_a, 1'b0};
                booth_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                booth_op  = {{2{op_a[31]}}, op_a};
                booth_neg = 1'b1;
            end
            default: booth_op = '0;
        endcase
        mul_sum = add34(acc_hi, booth_neg ? ~booth_op : booth_op, booth_neg);
        r_sh    = {acc_hi[31:0], acc_lo[31]};
        div_sum = add34({r_sh[32], r_sh},
                        acc_hi[32] ? {2'b00, op_b} : ~{2'b00, op_b},
                        ~acc_hi[32]);
        p_top   = {acc_hi[31:0], acc_lo[31]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            guard     <= 1'b0;
            loaded    <= 1'b0;
            q_sign    <= 1'b0;
            div_ovf   <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
            rdy       <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                op_a   <= bus.data_operandA;
                op_b   <= bus.data_operandB;
                count  <= '0;
                loaded <= 1'b0;
                acc_hi <= '0;
                acc_lo <= bus.data_operandB;
                guard  <= 1'b0;
                state  <= bus.ctrl_MULT ? S_MUL : S_DIV;
            end else begin
                case (state)
                    S_MUL: begin
                        if (count == 5'd16) begin
                            result    <= acc_lo;
                            exception <= ~((&p_top) | ~(|p_top));
                            rdy       <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            acc_hi <= {{2{mul_sum[33]}}, mul_sum[33:2]};
                            acc_lo <= {mul_sum[1:0], acc_lo[31:2]};
                            guard  <= acc_lo[1];
                            count  <= count + 5'd1;
                        end
                    end
                    S_DIV: begin
                        if (!loaded) begin
                            acc_hi  <= '0;
                            acc_lo  <= op_a[31] ? (32'd0 - op_a) : op_a;
                            op_b    <= op_b[31] ? (32'd0 - op_b) : op_b;
                            q_sign  <= op_a[31] ^ op_b[31];
                            div_ovf <= (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
                            loaded  <= 1'b1;
                        end else begin
                            acc_hi <= div_sum;
                            acc_lo <= {acc_lo[30:0], ~div_sum[33]};
                            if (count == 5'd31) state <= S_FIX;
                            else                count <= count + 5'd1;
                        end
                    end
                    S_FIX: begin
                        if (op_b == 32'd0) begin
                            result    <= 32'd0;
                            exception <= 1'b1;
                        end else if (div_ovf) begin
                            result    <= 32'h8000_0000;
                            exception <= 1'b1;
                        end else begin
                            result    <= q_sign ? (32'd0 - acc_lo) : acc_lo;
                            exception <= 1'b0;
                        end
                        rdy   <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/multdiv.md
# multdiv

Multicycle signed 32-bit multiplier/divider that sits downstream of the ALU's carry-lookahead adder datapath and consumes it. It is built from the same 8-bit CLA slices, chained into a 32-bit adder/subtractor, and iterates over it rather than instantiating a combinational array. The processor's execute stage starts an operation with a one-cycle control pulse and stalls until `data_resultRDY` is asserted.

## Interface
- No parameters; width fixed at 32 bits.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all outputs immediately.
- `data_operandA`  in  32  multiplicand / dividend, two's complement; sampled only on a start edge.
- `data_operandB`  in  32  multiplier / divisor, two's complement; sampled only on a start edge.
- `ctrl_MULT`  in  1  start-multiply pulse.
- `ctrl_DIV`  in  1  start-divide pulse.
- `data_result`  out  32  low 32 bits of product, or quotient.
- `data_exception`  out  1  overflow or divide-by-zero flag for the current result.
- `data_resultRDY`  out  1  one-cycle pulse: result valid.

## Operation
- States: IDLE, MUL, DIV, FIX.
- In any state, a rising edge with `ctrl_MULT`=1 latches both operands, clears the iteration counter, and enters MUL.
- Otherwise, a rising edge with `ctrl_DIV`=1 does the same and enters DIV.
- `ctrl_MULT` and `ctrl_DIV` both high on the same edge: multiply wins.
- A start edge during MUL/DIV/FIX aborts the in-flight operation: no RDY pulse for it, and outputs keep their previous values.
- MUL, radix-4 modified Booth:
  - 16 iterations, one per cycle.
  - Each cycle adds 0, ±A or ±2A to the upper half of a 65-bit accumulator {P[63:0], guard bit} via the 32-bit CLA, then arithmetic-shifts right by 2.
  - After iteration 16: result = P[31:0]; exception = 1 iff P[63:31] is not all-equal (signed overflow); return to IDLE.
- DIV, non-restoring on magnitudes:
  - Load captures |A|, |B| and the quotient sign (A[31]^B[31]).
  - 32 iterations, one per cycle: shift {R,Q} left 1; R ±= |B| based on sign of R; set Q bit.
  - Then enter FIX.
- FIX (1 cycle): negate Q if the quotient sign is 1. Quotient truncates toward zero; the remainder is discarded.
- Division special cases, applied in FIX:
  - B = 0: result 0x00000000, exception 1.
  - A = 0x80000000 and B = 0xFFFFFFFF: result 0x80000000, exception 1.
  - All other cases: exception 0.
- `data_result` and `data_exception` update only on the RDY edge and hold until the next completed operation.

## Timing
- Reset: `data_result`=0, `data_exception`=0, `data_resultRDY`=0, state IDLE, counter 0. Takes effect asynchronously and aborts any operation.
- Cycle 0 is the edge at which the start pulse is sampled.
- Multiply: `data_resultRDY`=1 for the cycle following edge 17 (16 iterations + 1 writeback), 0 otherwise.
- Divide: `data_resultRDY`=1 following edge 34 (1 load + 32 iterations + 1 FIX). Divide-by-zero uses the same latency.
- Back-to-back: a start pulse in the RDY cycle is legal. The new operation begins and the pulse completes normally.
- Start pulses are one cycle wide. If held high, the unit restarts every cycle and never completes.
- Iteration counter: 5 bits; it does not wrap during a legal operation.
- Operand inputs may change freely after cycle 0.

## Test plan
- Reset mid-operation:
  - Stimulus: start a multiply, assert `reset` at cycle 8, release it.
  - Required response: all outputs 0 immediately, no RDY pulse; a fresh multiply then completes at 17.
- Signed multiply:
  - Stimulus: A=7, B=0xFFFFFFFD (−3).
  - Required response: at cycle 17, result 0xFFFFFFEB, exception 0, RDY high exactly one cycle.
- Multiply overflow:
  - Stimulus 1: A=0x00010000, B=0x00010000. Required response: result 0x00000000, exception 1.
  - Stimulus 2: A=0x80000000, B=1. Required response: result 0x80000000, exception 0.
- Signed divide:
  - Stimulus 1: A=0xFFFFFFF9 (−7), B=2. Required response: at cycle 34, result 0xFFFFFFFD, exception 0.
  - Stimulus 2: A=100, B=7. Required response: result 14.
- Divide special cases:
  - Stimulus 1: A=5, B=0. Required response: result 0, exception 1 at cycle 34.
  - Stimulus 2: A=0x80000000, B=0xFFFFFFFF. Required response: result 0x80000000, exception 1.
- Abort and priority:
  - Stimulus 1: pulse `ctrl_DIV` at cycle 5 of a multiply (A=20, B=4). Required response: exactly one RDY, 34 cycles after the DIV pulse, result 5.
  - Stimulus 2: pulse both controls together. Required response: multiply result at cycle 17.
